// File: rtl/ysyx_23060025_lsu.sv
// Load/store unit between EXU and WBU: latches one op, runs a single-beat bus transaction for loads/stores.
// Non-memory ops present one cycle after acceptance; memory ops after DONE. WBU back-pressure holds all state.
module ysyx_23060025_lsu #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  es_to_ms_valid,
  output logic                  ms_allowin_o,
  input  logic                  wd_i,
  input  logic [4:0]            wreg_i,
  input  logic [DATA_LEN-1:0]   alu_result_i,
  input  logic [DATA_LEN-1:0]   store_data_i,
  input  logic                  mem_ren_i,
  input  logic                  mem_wen_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_sext_i,
  input  logic [DATA_LEN-1:0]   csr_wdata_i,
  input  logic [DATA_LEN-1:0]   csr_mcause_i,
  input  logic [2:0]            csr_type_i,
  input  logic [11:0]           csr_waddr_i,
  input  logic                  ebreak_flag_i,
  output logic                  ms_to_ws_valid,
  input  logic                  ws_allowin_i,
  output logic                  wd_o,
  output logic [4:0]            wreg_o,
  output logic [DATA_LEN-1:0]   reg_wdata_o,
  output logic [DATA_LEN-1:0]   csr_wdata_o,
  output logic [2:0]            csr_type_o,
  output logic [11:0]           csr_waddr_o,
  output logic [DATA_LEN-1:0]   csr_mcause_o,
  output logic                  ebreak_flag_o,
  output logic                  lsu_exc_o,
  output logic [3:0]            lsu_exc_code_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_LEN-1:0]   req_addr_o,
  output logic [DATA_LEN-1:0]   req_wdata_o,
  output logic                  req_wen_o,
  output logic [DATA_LEN/8-1:0] req_wstrb_o,
  input  logic                  resp_valid_i,
  input  logic [DATA_LEN-1:0]   resp_rdata_i,
  input  logic                  resp_err_i
);

  localparam int STRB_W = DATA_LEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic                wd;
    logic [4:0]          wreg;
    logic [DATA_LEN-1:0] alu_result;
    logic [DATA_LEN-1:0] store_data;
    logic                ren;
    logic                wen;
    logic [1:0]          size;
    logic                sext;
    logic [DATA_LEN-1:0] csr_wdata;
    logic [DATA_LEN-1:0] csr_mcause;
    logic [2:0]          csr_type;
    logic [11:0]         csr_waddr;
    logic                ebreak;
  } ms_t;

  state_t              state, state_nxt;
  ms_t                 ms;
  logic                ms_valid;
  logic                ms_mem;
  logic                ms_ready_go;
  logic                accept;
  logic                in_mem;
  logic                in_misaligned;
  logic                exc_q, exc_nxt;
  logic [3:0]          code_q, code_nxt;
  logic [DATA_LEN-1:0] rdata_q, rdata_nxt;
  logic [1:0]          off;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [DATA_LEN-1:0] load_data;
  logic [STRB_W-1:0]   strb;

  assign ms_mem         = ms.ren | ms.wen;
  assign ms_ready_go    = !ms_mem || (state == DONE);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  // Held low during reset so the whole port reads zero while reset is asserted.
  assign ms_allowin_o   = reset & (!ms_valid | (ms_ready_go & ws_allowin_i));
  assign accept         = es_to_ms_valid & ms_allowin_o;

  assign in_mem        = mem_ren_i | mem_wen_i;
  assign in_misaligned = ((mem_size_i == 2'b01) & alu_result_i[0]) |
                         (mem_size_i[1] & (|alu_result_i[1:0]));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      exc_q   <= 1'b0;
      code_q  <= 4'd0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      exc_q   <= exc_nxt;
      code_q  <= code_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    exc_nxt   = exc_q;
    code_nxt  = code_q;
    rdata_nxt = rdata_q;
    if (accept) begin
      exc_nxt   = 1'b0;
      code_nxt  = 4'd0;
      rdata_nxt = '0;
      if (!in_mem) begin
        state_nxt = IDLE;
      end else if (in_misaligned) begin
        state_nxt = DONE;
        exc_nxt   = 1'b1;
        code_nxt  = mem_wen_i ? 4'd6 : 4'd4;
      end else begin
        state_nxt = REQ;
      end
    end else begin
      case (state)
        REQ:  if (req_ready_i) state_nxt = WAIT;
        WAIT: if (resp_valid_i) begin
          state_nxt = DONE;
          rdata_nxt = resp_rdata_i;
          if (resp_err_i) begin
            exc_nxt  = 1'b1;
            code_nxt = ms.wen ? 4'd7 : 4'd5;
          end
        end
        DONE: if (ws_allowin_i) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms_valid <= 1'b0;
      ms       <= '0;
    end else if (accept) begin
      ms_valid <= 1'b1;
      ms       <= '{wd: wd_i, wreg: wreg_i, alu_result: alu_result_i,
                    store_data: store_data_i, ren: mem_ren_i, wen: mem_wen_i,
                    size: mem_size_i, sext: mem_sext_i, csr_wdata: csr_wdata_i,
                    csr_mcause: csr_mcause_i, csr_type: csr_type_i,
                    csr_waddr: csr_waddr_i, ebreak: ebreak_flag_i};
    end else if (ms_to_ws_valid & ws_allowin_i) begin
      ms_valid <= 1'b0;
    end
  end

  assign off = ms.alu_result[1:0];

  always_comb begin
    lane_b = resp_lane(rdata_q, off);
    lane_h = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (ms.size)
      2'b00:   load_data = {{(DATA_LEN-8){ms.sext & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{(DATA_LEN-16){ms.sext & lane_h[15]}}, lane_h};
      default: load_data = rdata_q;
    endcase
  end

  function automatic logic [7:0] resp_lane(input logic [DATA_LEN-1:0] d, input logic [1:0] o);
    case (o)
      2'd0:    resp_lane = d[7:0];
      2'd1:    resp_lane = d[15:8];
      2'd2:    resp_lane = d[23:16];
      default: resp_lane = d[31:24];
    endcase
  endfunction

  always_comb begin
    case (ms.size)
      2'b00:   strb = {{(STRB_W-1){1'b0}}, 1'b1} << off;
      2'b01:   strb = {{(STRB_W-2){1'b0}}, 2'b11} << off;
      default: strb = '1;
    endcase
  end

  // Request fields read zero outside REQ and stay frozen while REQ waits for ready.
  assign req_valid_o = (state == REQ);
  assign req_addr_o  = req_valid_o ? ms.alu_result[ADDR_LEN-1:0] : '0;
  assign req_wdata_o = req_valid_o ? (ms.store_data << {off, 3'b000}) : '0;
  assign req_wen_o   = req_valid_o & ms.wen;
  assign req_wstrb_o = req_valid_o ? strb : '0;

  assign lsu_exc_o      = exc_q & ms_to_ws_valid;
  assign lsu_exc_code_o = lsu_exc_o ? code_q : 4'd0;
  assign wd_o           = ms.wd & ms_to_ws_valid & !exc_q;
  assign wreg_o         = ms.wreg;
  assign reg_wdata_o    = ms.ren ? load_data : ms.alu_result;
  assign csr_wdata_o    = ms.csr_wdata;
  assign csr_type_o     = ms_to_ws_valid ? ms.csr_type : 3'd0;
  assign csr_waddr_o    = ms.csr_waddr;
  assign csr_mcause_o   = ms.csr_mcause;
  assign ebreak_flag_o  = ms.ebreak;

endmodule

// File: tb/tb_ysyx_23060025_lsu.sv
// Directed bench for ysyx_23060025_lsu: vector table plus hand sequences for stalls, back-to-back and reset.
module tb_ysyx_23060025_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        es_to_ms_valid, ms_allowin_o;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        mem_ren_i, mem_wen_i, mem_sext_i;
  logic [1:0]  mem_size_i;
  logic [31:0] csr_wdata_i, csr_mcause_i;
  logic [2:0]  csr_type_i;
  logic [11:0] csr_waddr_i;
  logic        ebreak_flag_i;
  logic        ms_to_ws_valid, ws_allowin_i;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] reg_wdata_o, csr_wdata_o, csr_mcause_o;
  logic [2:0]  csr_type_o;
  logic [11:0] csr_waddr_o;
  logic        ebreak_flag_o, lsu_exc_o;
  logic [3:0]  lsu_exc_code_o;
  logic        req_valid_o, req_ready_i;
  logic [31:0] req_addr_o, req_wdata_o;
  logic        req_wen_o;
  logic [3:0]  req_wstrb_o;
  logic        resp_valid_i, resp_err_i;
  logic [31:0] resp_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_23060025_lsu dut (
    .clock(clock), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin_o(ms_allowin_o),
    .wd_i(wd_i), .wreg_i(wreg_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i), .mem_size_i(mem_size_i), .mem_sext_i(mem_sext_i),
    .csr_wdata_i(csr_wdata_i), .csr_mcause_i(csr_mcause_i), .csr_type_i(csr_type_i),
    .csr_waddr_i(csr_waddr_i), .ebreak_flag_i(ebreak_flag_i),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin_i(ws_allowin_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .reg_wdata_o(reg_wdata_o), .csr_wdata_o(csr_wdata_o),
    .csr_type_o(csr_type_o), .csr_waddr_o(csr_waddr_o), .csr_mcause_o(csr_mcause_o),
    .ebreak_flag_o(ebreak_flag_o), .lsu_exc_o(lsu_exc_o), .lsu_exc_code_o(lsu_exc_code_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_wdata_o(req_wdata_o), .req_wen_o(req_wen_o), .req_wstrb_o(req_wstrb_o),
    .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i), .resp_err_i(resp_err_i)
  );

  typedef struct {
    logic        ren, wen;
    logic [1:0]  size;
    logic        sext, wd;
    logic [31:0] addr, sdata, rdata;
    logic        err;
    logic        exp_req;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_exc;
    logic [3:0]  exp_code;
    logic        exp_wd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic ren, logic wen, logic [1:0] size, logic sext, logic wd,
                              logic [31:0] addr, logic [31:0] sdata, logic [31:0] rdata, logic err,
                              logic ereq, logic [3:0] estrb, logic [31:0] ewdata, logic chk,
                              logic [31:0] erd, logic eexc, logic [3:0] ecode, logic ewd, int elat);
    vec_t v;
    v = '{ren, wen, size, sext, wd, addr, sdata, rdata, err,
          ereq, estrb, ewdata, chk, erd, eexc, ecode, ewd, elat};
    return v;
  endfunction

  task automatic drive_op(input logic ren, input logic wen, input logic [1:0] size,
                          input logic sext, input logic wd, input logic [31:0] addr,
                          input logic [31:0] sdata);
    mem_ren_i = ren; mem_wen_i = wen; mem_size_i = size; mem_sext_i = sext;
    wd_i = wd; alu_result_i = addr; store_data_i = sdata;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat;
    bit saw;
    logic [95:0] pt;
    @(negedge clock);
    drive_op(v.ren, v.wen, v.size, v.sext, v.wd, v.addr, v.sdata);
    wreg_i = i[4:0]; csr_wdata_i = 32'h1000_0000 + i; csr_mcause_i = 32'(i * 3);
    csr_type_i = i[2:0]; csr_waddr_i = 12'h300 + 12'(i); ebreak_flag_i = i[0];
    es_to_ms_valid = 1'b1;
    check($sformatf("v%0d allowin", i), 96'(ms_allowin_o), 96'(1));
    @(negedge clock);
    es_to_ms_valid = 1'b0;
    lat = 1; saw = 1'b0;
    while (!ms_to_ws_valid && lat < 20) begin
      if (req_valid_o && !saw) begin
        saw = 1'b1;
        check($sformatf("v%0d req_addr", i), 96'(req_addr_o), 96'(v.addr));
        check($sformatf("v%0d req_wen", i), 96'(req_wen_o), 96'(v.wen));
        if (v.wen) begin
          check($sformatf("v%0d wstrb", i), 96'(req_wstrb_o), 96'(v.exp_strb));
          check($sformatf("v%0d wdata", i), 96'(req_wdata_o), 96'(v.exp_wdata));
        end
        req_ready_i = 1'b1;
        @(negedge clock);
        req_ready_i = 1'b0;
        resp_valid_i = 1'b1; resp_rdata_i = v.rdata; resp_err_i = v.err;
        @(negedge clock);
        resp_valid_i = 1'b0; resp_err_i = 1'b0;
        lat += 2;
      end else begin
        @(negedge clock);
        lat++;
      end
    end
    check($sformatf("v%0d presented", i), 96'(ms_to_ws_valid), 96'(1));
    check($sformatf("v%0d latency", i), 96'(lat), 96'(v.exp_lat));
    check($sformatf("v%0d req_seen", i), 96'(saw), 96'(v.exp_req));
    if (v.chk_rd) check($sformatf("v%0d reg_wdata", i), 96'(reg_wdata_o), 96'(v.exp_rd));
    check($sformatf("v%0d exc", i), 96'({lsu_exc_o, lsu_exc_code_o}), 96'({v.exp_exc, v.exp_code}));
    check($sformatf("v%0d wd_o", i), 96'(wd_o), 96'(v.exp_wd));
    pt = {11'd0, wreg_o, csr_wdata_o, csr_type_o, csr_waddr_o, csr_mcause_o, ebreak_flag_o};
    check($sformatf("v%0d passthru", i), pt,
          {11'd0, 5'(i), 32'h1000_0000 + 32'(i), 3'(i), 12'h300 + 12'(i), 32'(i * 3), 1'(i)});
  endtask

  logic [95:0] all_out;
  always_comb all_out = {ms_allowin_o, ms_to_ws_valid, wd_o, wreg_o, reg_wdata_o[15:0],
                         csr_type_o, lsu_exc_o, lsu_exc_code_o, req_valid_o, req_addr_o,
                         req_wen_o, req_wstrb_o, req_wdata_o[23:0]};

  initial begin
    reset = 1'b0; es_to_ms_valid = 1'b0; ws_allowin_i = 1'b1;
    drive_op(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wreg_i = 5'd0; csr_wdata_i = 32'd0; csr_mcause_i = 32'd0; csr_type_i = 3'd0;
    csr_waddr_i = 12'd0; ebreak_flag_i = 1'b0;
    req_ready_i = 1'b0; resp_valid_i = 1'b0; resp_rdata_i = 32'd0; resp_err_i = 1'b0;

    //          ren  wen  size sx  wd  addr          sdata         rdata         err  req strb   wdata         chk rd            exc code wd lat
    vecs[0]  = mk(0, 0, 2'd0, 0, 1, 32'h0000_1234, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        1, 32'h0000_1234, 0, 4'd0, 1, 1);
    vecs[1]  = mk(1, 0, 2'd0, 1, 1, 32'h8000_0003, 32'h0,        32'h80FF_0000, 0, 1, 4'h0, 32'h0,       1, 32'hFFFF_FF80, 0, 4'd0, 1, 3);
    vecs[2]  = mk(1, 0, 2'd0, 0, 1, 32'h8000_0003, 32'h0,        32'h80FF_0000, 0, 1, 4'h0, 32'h0,       1, 32'h0000_0080, 0, 4'd0, 1, 3);
    vecs[3]  = mk(0, 1, 2'd1, 0, 0, 32'h8000_0002, 32'h0000_ABCD, 32'h0,       0, 1, 4'hC, 32'hABCD_0000, 0, 32'h0,         0, 4'd0, 0, 3);
    vecs[4]  = mk(1, 0, 2'd2, 0, 1, 32'h8000_0002, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        0, 32'h0,         1, 4'd4, 0, 1);
    vecs[5]  = mk(1, 0, 2'd1, 1, 1, 32'h8000_0002, 32'h0,        32'h8001_1234, 0, 1, 4'h0, 32'h0,       1, 32'hFFFF_8001, 0, 4'd0, 1, 3);
    vecs[6]  = mk(1, 0, 2'd1, 0, 1, 32'h8000_0000, 32'h0,        32'h8001_F234, 0, 1, 4'h0, 32'h0,       1, 32'h0000_F234, 0, 4'd0, 1, 3);
    vecs[7]  = mk(1, 0, 2'd2, 0, 1, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 0, 1, 4'h0, 32'h0,       1, 32'hDEAD_BEEF, 0, 4'd0, 1, 3);
    vecs[8]  = mk(0, 1, 2'd0, 0, 0, 32'h8000_0001, 32'h1234_56AA, 32'h0,       0, 1, 4'h2, 32'h3456_AA00, 0, 32'h0,         0, 4'd0, 0, 3);
    vecs[9]  = mk(0, 1, 2'd2, 0, 0, 32'h8000_0008, 32'hCAFE_BABE, 32'h0,       0, 1, 4'hF, 32'hCAFE_BABE, 0, 32'h0,         0, 4'd0, 0, 3);
    vecs[10] = mk(0, 1, 2'd1, 0, 1, 32'h8000_0001, 32'h0000_1111, 32'h0,       0, 0, 4'h0, 32'h0,        0, 32'h0,         1, 4'd6, 0, 1);
    vecs[11] = mk(1, 0, 2'd2, 0, 1, 32'h8000_0010, 32'h0,        32'h1234_5678, 1, 1, 4'h0, 32'h0,       0, 32'h0,         1, 4'd5, 0, 3);
    vecs[12] = mk(0, 1, 2'd2, 0, 0, 32'h8000_0014, 32'h0102_0304, 32'h0,       1, 1, 4'hF, 32'h0102_0304, 0, 32'h0,         1, 4'd7, 0, 3);
    vecs[13] = mk(1, 0, 2'd0, 1, 1, 32'h8000_0001, 32'h0,        32'h0000_7F00, 0, 1, 4'h0, 32'h0,       1, 32'h0000_007F, 0, 4'd0, 1, 3);
    vecs[14] = mk(1, 0, 2'd1, 0, 1, 32'h8000_0003, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        0, 32'h0,         1, 4'd4, 0, 1);
    vecs[15] = mk(0, 0, 2'd0, 0, 0, 32'hFFFF_FFFF, 32'h0,        32'h0,        0, 0, 4'h0, 32'h0,        1, 32'hFFFF_FFFF, 0, 4'd0, 0, 1);
    vecs[16] = mk(1, 0, 2'd1, 1, 1, 32'h8000_0000, 32'h0,        32'hFFFF_7FFF, 0, 1, 4'h0, 32'h0,       1, 32'h0000_7FFF, 0, 4'd0, 1, 3);

    #1;
    check("reset outputs", all_out, 96'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("post-reset idle", 96'({ms_allowin_o, ms_to_ws_valid, req_valid_o}), 96'(3'b100));

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Request stall for 5 cycles, then WBU back-pressure for 3 cycles with a stray response.
    @(negedge clock);
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h8000_0020, 32'h0);
    es_to_ms_valid = 1'b1;
    @(negedge clock);
    es_to_ms_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d req", k),
            96'({req_valid_o, req_addr_o, req_wen_o, ms_allowin_o, ms_to_ws_valid}),
            96'({1'b1, 32'h8000_0020, 1'b0, 1'b0, 1'b0}));
      @(negedge clock);
    end
    check("stall end req", 96'({req_valid_o, req_addr_o}), 96'({1'b1, 32'h8000_0020}));
    req_ready_i = 1'b1; ws_allowin_i = 1'b0;
    @(negedge clock);
    req_ready_i = 1'b0; resp_valid_i = 1'b1; resp_rdata_i = 32'h1122_3344;
    @(negedge clock);
    resp_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d out", k),
            96'({ms_to_ws_valid, ms_allowin_o, wd_o, req_valid_o, lsu_exc_o, reg_wdata_o}),
            96'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1122_3344}));
      resp_valid_i = (k == 1); resp_rdata_i = 32'h0BAD_0BAD;
      @(negedge clock);
      resp_valid_i = 1'b0;
    end
    ws_allowin_i = 1'b1;
    @(negedge clock);
    check("bp retired", 96'({ms_to_ws_valid, ms_allowin_o}), 96'(2'b01));

    // Back-to-back: a new load accepted in the same cycle the previous one retires.
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h8000_0040, 32'h0);
    es_to_ms_valid = 1'b1;
    @(negedge clock);
    es_to_ms_valid = 1'b0;
    req_ready_i = 1'b1;
    @(negedge clock);
    req_ready_i = 1'b0; resp_valid_i = 1'b1; resp_rdata_i = 32'hAAAA_AAAA;
    @(negedge clock);
    resp_valid_i = 1'b0;
    check("b2b first", 96'({ms_to_ws_valid, ms_allowin_o, reg_wdata_o}), 96'({2'b11, 32'hAAAA_AAAA}));
    drive_op(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h8000_0041, 32'h0);
    es_to_ms_valid = 1'b1;
    @(negedge clock);
    es_to_ms_valid = 1'b0;
    check("b2b second req", 96'({req_valid_o, ms_to_ws_valid, req_addr_o}), 96'({2'b10, 32'h8000_0041}));
    req_ready_i = 1'b1;
    @(negedge clock);
    req_ready_i = 1'b0; resp_valid_i = 1'b1; resp_rdata_i = 32'h0000_AB00;
    @(negedge clock);
    resp_valid_i = 1'b0;
    check("b2b second data", 96'({ms_to_ws_valid, reg_wdata_o}), 96'({1'b1, 32'h0000_00AB}));

    // Reset while the request is outstanding in REQ.
    @(negedge clock);
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h8000_0050, 32'h0);
    es_to_ms_valid = 1'b1;
    @(negedge clock);
    es_to_ms_valid = 1'b0;
    check("rst-req pre", 96'(req_valid_o), 96'(1));
    reset = 1'b0;
    #1;
    check("rst-req outputs", all_out, 96'd0);
    @(negedge clock);
    reset = 1'b1;

    // Reset in WAIT, then a stale response after release.
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h8000_0060, 32'h0);
    es_to_ms_valid = 1'b1;
    @(negedge clock);
    es_to_ms_valid = 1'b0;
    req_ready_i = 1'b1;
    @(negedge clock);
    req_ready_i = 1'b0;
    check("rst-wait pre", 96'({req_valid_o, ms_to_ws_valid, ms_allowin_o}), 96'(3'b000));
    reset = 1'b0;
    #1;
    check("rst-wait outputs", all_out, 96'd0);
    @(negedge clock);
    reset = 1'b1; resp_valid_i = 1'b1; resp_rdata_i = 32'h5555_5555;
    @(negedge clock);
    resp_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stale%0d", k), 96'({ms_to_ws_valid, req_valid_o, ms_allowin_o, wd_o}), 96'(4'b0010));
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
